// File: rtl/alarma_multicanal_if.sv
// Front-panel bundle for alarma_multicanal: button levels and acknowledge in,
// light, aggregate alarm flag and event count out.
interface alarma_multicanal_if #(
  parameter int unsigned CANALES = 4
);
  logic [CANALES-1:0] Button;
  logic               ACK;
  logic [CANALES-1:0] LUZ;
  logic               ALARMA;
  logic [7:0]         CUENTA;

  // master drives the panel side, slave is the alarm controller
  modport master (
    output Button,
    output ACK,
    input  LUZ,
    input  ALARMA,
    input  CUENTA
  );

  modport slave (
    input  Button,
    input  ACK,
    output LUZ,
    output ALARMA,
    output CUENTA
  );
endinterface

// File: rtl/alarma_multicanal.sv
// Multi-channel debounced alarm controller with latched lights, aggregate flag and saturating
// event counter. Define ALARMA_PARPADEO_EN to make active lights blink.
module alarma_multicanal #(
  parameter int unsigned CANALES         = 4,
  parameter int unsigned DEBOUNCE_CICLOS = 3,
  parameter int unsigned PARPADEO_DIV    = 8
) (
  input logic                CLK,
  input logic                RST,
  alarma_multicanal_if.slave bus
);

  if (CANALES < 1 || CANALES > 16 || DEBOUNCE_CICLOS < 1 || PARPADEO_DIV < 1) begin : g_param_chk
    $error("alarma_multicanal: parameter out of range");
  end

  localparam int unsigned DbW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {StReposo, StActiva, StEsperaLibera} estado_e;

  estado_e            estado_q [CANALES];
  estado_e            estado_d [CANALES];
  logic [DbW-1:0]     db_q     [CANALES];
  logic [DbW-1:0]     db_d     [CANALES];
  logic [CANALES-1:0] entra;
  logic [CANALES-1:0] activa_d;
  logic [CANALES-1:0] luz_q, luz_d;
  logic               alarma_q, alarma_d;
  logic [7:0]         cuenta_q, cuenta_d;
  logic [4:0]         n_entradas;
  logic [8:0]         suma;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < CANALES; i++) begin
        estado_q[i] <= StReposo;
        db_q[i]     <= '0;
      end
      luz_q    <= '0;
      alarma_q <= 1'b0;
      cuenta_q <= '0;
    end else begin
      for (int i = 0; i < CANALES; i++) begin
        estado_q[i] <= estado_d[i];
        db_q[i]     <= db_d[i];
      end
      luz_q    <= luz_d;
      alarma_q <= alarma_d;
      cuenta_q <= cuenta_d;
    end
  end

  // Next-state logic; the debounce counter only runs in StReposo
  always_comb begin
    entra = '0;
    for (int i = 0; i < CANALES; i++) begin
      estado_d[i] = estado_q[i];
      db_d[i]     = '0;
      unique case (estado_q[i])
        StReposo: begin
          if (bus.Button[i]) begin
            if (db_q[i] == DbMax) begin
              estado_d[i] = StActiva;
              entra[i]    = 1'b1;
            end else begin
              db_d[i] = db_q[i] + DbW'(1);
            end
          end
        end
        StActiva: begin
          if (bus.ACK) estado_d[i] = bus.Button[i] ? StEsperaLibera : StReposo;
        end
        StEsperaLibera: begin
          if (!bus.Button[i]) estado_d[i] = StReposo;
        end
        default: estado_d[i] = StReposo;
      endcase
    end
  end

`ifdef ALARMA_PARPADEO_EN
  localparam int unsigned PdW = $clog2(PARPADEO_DIV) + 1;
  localparam logic [PdW-1:0] PdMax = PdW'(PARPADEO_DIV - 1);

  logic [PdW-1:0]     parp_q [CANALES];
  logic [PdW-1:0]     parp_d [CANALES];
  logic [CANALES-1:0] fase_q, fase_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < CANALES; i++) parp_q[i] <= '0;
      fase_q <= '0;
    end else begin
      for (int i = 0; i < CANALES; i++) parp_q[i] <= parp_d[i];
      fase_q <= fase_d;
    end
  end

  // Light starts on at entry and toggles every PARPADEO_DIV edges spent in StActiva
  always_comb begin
    fase_d = '0;
    for (int i = 0; i < CANALES; i++) begin
      parp_d[i] = '0;
      if (entra[i]) begin
        fase_d[i] = 1'b1;
      end else if (estado_q[i] == StActiva && estado_d[i] == StActiva) begin
        if (parp_q[i] == PdMax) begin
          fase_d[i] = ~fase_q[i];
        end else begin
          parp_d[i] = parp_q[i] + PdW'(1);
          fase_d[i] = fase_q[i];
        end
      end
    end
  end
`else
  logic [CANALES-1:0] fase_d;
  assign fase_d = '1;
`endif

  // Output logic, computed from next state so the outputs land on the same edge
  always_comb begin
    n_entradas = '0;
    for (int i = 0; i < CANALES; i++) begin
      activa_d[i] = (estado_d[i] == StActiva);
      n_entradas  = n_entradas + 5'(entra[i]);
    end
    luz_d    = activa_d & fase_d;
    alarma_d = |activa_d;
    suma     = {1'b0, cuenta_q} + 9'(n_entradas);
    cuenta_d = suma[8] ? 8'hFF : suma[7:0];
  end

  assign bus.LUZ    = luz_q;
  assign bus.ALARMA = alarma_q;
  assign bus.CUENTA = cuenta_q;

endmodule

// File: tb/tb_alarma_multicanal.sv
// Directed bench for alarma_multicanal (CANALES=4, DEBOUNCE_CICLOS=3, PARPADEO_DIV=8).
module tb_alarma_multicanal;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cuenta = 0;

  alarma_multicanal_if #(.CANALES(4)) bus ();

  alarma_multicanal #(
    .CANALES        (4),
    .DEBOUNCE_CICLOS(3),
    .PARPADEO_DIV   (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic raise(input logic [3:0] mask);
    bus.Button = mask;
    repeat (3) tick();
  endtask

  task automatic clear_all();
    bus.Button = 4'b0000;
    bus.ACK    = 1'b1;
    tick();
    bus.ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b0;
    bus.Button = 4'b1111;
    bus.ACK    = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({bus.LUZ, bus.ALARMA, bus.CUENTA} !== 13'd0) begin
      n_err++;
      $display("FAIL reset: LUZ=%b ALARMA=%b CUENTA=%0d, required all 0",
               bus.LUZ, bus.ALARMA, bus.CUENTA);
    end
    RST        = 1'b1;
    bus.Button = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (bus.LUZ !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        n_err++;
        $display("FAIL press_latency edge %0d: LUZ=%b", k, bus.LUZ);
      end
    end
    exp_cuenta = 1;
    n_cmp++;
    if (bus.ALARMA !== 1'b1 || bus.CUENTA !== 8'(exp_cuenta)) begin
      n_err++;
      $display("FAIL first_alarm: ALARMA=%b CUENTA=%0d, required 1 and %0d",
               bus.ALARMA, bus.CUENTA, exp_cuenta);
    end
    clear_all();
    n_cmp++;
    if (bus.LUZ !== 4'b0000 || bus.ALARMA !== 1'b0) begin
      n_err++;
      $display("FAIL ack_release: LUZ=%b ALARMA=%b, required 0000 and 0", bus.LUZ, bus.ALARMA);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] pat [5];
    pat = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    for (int k = 0; k < 5; k++) begin
      bus.Button = pat[k];
      tick();
      n_cmp++;
      if (bus.LUZ !== 4'b0000 || bus.CUENTA !== 8'(exp_cuenta)) begin
        n_err++;
        $display("FAIL glitch step %0d: LUZ=%b CUENTA=%0d, required 0000 and %0d",
                 k, bus.LUZ, bus.CUENTA, exp_cuenta);
      end
    end
    bus.Button = 4'b0000;
    tick();
  endtask

  task automatic test_ack_held();
    raise(4'b0100);
    exp_cuenta++;
    n_cmp++;
    if (bus.LUZ !== 4'b0100 || bus.CUENTA !== 8'(exp_cuenta)) begin
      n_err++;
      $display("FAIL ch2_alarm: LUZ=%b CUENTA=%0d, required 0100 and %0d",
               bus.LUZ, bus.CUENTA, exp_cuenta);
    end
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    n_cmp++;
    if (bus.LUZ !== 4'b0000 || bus.ALARMA !== 1'b0) begin
      n_err++;
      $display("FAIL ack_held_clear: LUZ=%b ALARMA=%b, required 0000 and 0", bus.LUZ, bus.ALARMA);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (bus.LUZ !== 4'b0000 || bus.CUENTA !== 8'(exp_cuenta)) begin
        n_err++;
        $display("FAIL no_retrigger cycle %0d: LUZ=%b CUENTA=%0d, required 0000 and %0d",
                 k, bus.LUZ, bus.CUENTA, exp_cuenta);
      end
    end
    bus.Button = 4'b0000;
    tick();
    raise(4'b0100);
    exp_cuenta++;
    n_cmp++;
    if (bus.LUZ !== 4'b0100 || bus.CUENTA !== 8'(exp_cuenta)) begin
      n_err++;
      $display("FAIL rearm: LUZ=%b CUENTA=%0d, required 0100 and %0d",
               bus.LUZ, bus.CUENTA, exp_cuenta);
    end
    clear_all();
  endtask

  task automatic test_simultaneous();
    bus.Button = 4'b1111;
    repeat (2) tick();
    n_cmp++;
    if (bus.LUZ !== 4'b0000) begin
      n_err++;
      $display("FAIL simul_early: LUZ=%b, required 0000", bus.LUZ);
    end
    tick();
    exp_cuenta += 4;
    n_cmp++;
    if (bus.LUZ !== 4'b1111 || bus.ALARMA !== 1'b1 || bus.CUENTA !== 8'(exp_cuenta)) begin
      n_err++;
      $display("FAIL simul: LUZ=%b ALARMA=%b CUENTA=%0d, required 1111 1 %0d",
               bus.LUZ, bus.ALARMA, bus.CUENTA, exp_cuenta);
    end
    clear_all();
  endtask

  task automatic test_ack_collision();
    bus.ACK = 1'b1;
    raise(4'b1000);
    exp_cuenta++;
    n_cmp++;
    if (bus.LUZ !== 4'b1000 || bus.ALARMA !== 1'b1 || bus.CUENTA !== 8'(exp_cuenta)) begin
      n_err++;
      $display("FAIL ack_collision_enter: LUZ=%b ALARMA=%b CUENTA=%0d, required 1000 1 %0d",
               bus.LUZ, bus.ALARMA, bus.CUENTA, exp_cuenta);
    end
    tick();
    n_cmp++;
    if (bus.LUZ !== 4'b0000 || bus.ALARMA !== 1'b0) begin
      n_err++;
      $display("FAIL ack_collision_clear: LUZ=%b ALARMA=%b, required 0000 0", bus.LUZ, bus.ALARMA);
    end
    bus.ACK    = 1'b0;
    bus.Button = 4'b0000;
    tick();
  endtask

  task automatic test_blink();
    logic exp_luz;
    raise(4'b0001);
    exp_cuenta++;
    for (int j = 0; j < 24; j++) begin
`ifdef ALARMA_PARPADEO_EN
      exp_luz = ((j / 8) % 2) == 0;
`else
      exp_luz = 1'b1;
`endif
      n_cmp++;
      if (bus.LUZ[0] !== exp_luz || bus.ALARMA !== 1'b1) begin
        n_err++;
        $display("FAIL blink cycle %0d: LUZ[0]=%b ALARMA=%b, required %b and 1",
                 j, bus.LUZ[0], bus.ALARMA, exp_luz);
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_saturation();
    while (exp_cuenta + 4 <= 253) begin
      raise(4'b1111);
      clear_all();
      exp_cuenta += 4;
    end
    while (exp_cuenta < 253) begin
      raise(4'b0001);
      clear_all();
      exp_cuenta++;
    end
    n_cmp++;
    if (bus.CUENTA !== 8'd253) begin
      n_err++;
      $display("FAIL count_253: CUENTA=%0d, required 253", bus.CUENTA);
    end
    raise(4'b1111);
    n_cmp++;
    if (bus.CUENTA !== 8'd255 || bus.LUZ !== 4'b1111) begin
      n_err++;
      $display("FAIL saturate: CUENTA=%0d LUZ=%b, required 255 and 1111", bus.CUENTA, bus.LUZ);
    end
    clear_all();
    raise(4'b0010);
    n_cmp++;
    if (bus.CUENTA !== 8'd255 || bus.LUZ !== 4'b0010) begin
      n_err++;
      $display("FAIL saturate_hold: CUENTA=%0d LUZ=%b, required 255 and 0010", bus.CUENTA, bus.LUZ);
    end
  endtask

  task automatic test_reset_mid_alarm();
    // channel 1 is still active from the previous task
    RST = 1'b0;
    tick();
    n_cmp++;
    if ({bus.LUZ, bus.ALARMA, bus.CUENTA} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_mid_alarm: LUZ=%b ALARMA=%b CUENTA=%0d, required all 0",
               bus.LUZ, bus.ALARMA, bus.CUENTA);
    end
    RST        = 1'b1;
    bus.Button = 4'b0000;
    tick();
  endtask

  initial begin
    RST        = 1'b0;
    bus.Button = 4'b0000;
    bus.ACK    = 1'b0;
    test_reset();
    test_glitch();
    test_ack_held();
    test_simultaneous();
    test_ack_collision();
    test_blink();
    test_saturation();
    test_reset_mid_alarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarma_multicanal.md
# alarma_multicanal

Parametrised multi-channel alarm controller, the next generation of the single-button/single-light alarm. Each of `CANALES` push-button inputs is debounced and drives its own latched light output until an operator acknowledge. It also provides an aggregate alarm flag and a saturating event counter. The block sits between the front-panel button synchronisers and the indicator drivers.

## Interface
- `CANALES`, 4: number of independent button/light channels (1–16).
- `DEBOUNCE_CICLOS`, 3: consecutive high samples required to accept a press (≥1).
- `PARPADEO_DIV`, 8: cycles per blink half-period; used only with blink enabled (≥1).
- `CLK`  in  1: single clock; all logic on rising edge.
- `RST`  in  1: synchronous, active-low reset.
- `Button`  in  CANALES: per-channel button level, already synchronised to `CLK`.
- `ACK`  in  1: acknowledge, level-sampled each edge.
- `LUZ`  out  CANALES: per-channel light, registered.
- `ALARMA`  out  1: registered OR of all channels in ACTIVA.
- `CUENTA`  out  8: registered count of accepted alarms, saturating at 255.

## Operation
- Per-channel FSM with states REPOSO, ACTIVA, ESPERA_LIBERA.
- Debounce counter, one per channel:
  - Increments on each edge with `Button[i]`=1.
  - Clears on any edge with `Button[i]`=0.
  - Saturates at `DEBOUNCE_CICLOS`-1.
- REPOSO → ACTIVA on the edge where `Button[i]`=1 and the counter already equals `DEBOUNCE_CICLOS`-1. With `DEBOUNCE_CICLOS`=1, the first high sample is enough.
- ACTIVA → ESPERA_LIBERA on an edge with `ACK`=1 and `Button[i]`=1.
- ACTIVA → REPOSO on an edge with `ACK`=1 and `Button[i]`=0.
- ESPERA_LIBERA → REPOSO on the first edge with `Button[i]`=0. Re-arming requires a release followed by a full new debounce.
- In REPOSO, the debounce counter runs normally. In ACTIVA and ESPERA_LIBERA, it is held at 0.
- `LUZ[i]`: see Configuration. Always 0 outside ACTIVA.
- `ALARMA` = 1 iff any channel is in ACTIVA (as of the same edge).
- `CUENTA` += number of channels entering ACTIVA on that edge, clamped to 255. It never wraps and only clears on reset.

## Timing
- Reset (`RST`=0 at an edge) drives all of the following on that edge, regardless of other inputs:
  - all FSMs to REPOSO;
  - debounce and blink counters to 0;
  - `LUZ`=0, `ALARMA`=0, `CUENTA`=0.
- Reset mid-alarm drops `LUZ` on that same edge.
- Press latency: if `Button[i]` is first sampled high at edge k and stays high, `LUZ[i]`/`ALARMA` go 1 after edge k+`DEBOUNCE_CICLOS`-1.
- ACK latency: `LUZ[i]`/`ALARMA` go 0 after the first edge sampling `ACK`=1.
- ACK held high does not block new alarms. A channel that completes debounce on an edge with `ACK`=1 still enters ACTIVA; ACK acts only on channels already in ACTIVA before that edge.
- Simultaneous entries on several channels update `CUENTA` in one edge by the popcount.
  - Example: `CUENTA`=254 with 3 entries → 255.
- A glitch shorter than `DEBOUNCE_CICLOS` samples never reaches ACTIVA.

## Configuration
- Macro `ALARMA_PARPADEO_EN`.
- Defined:
  - Each channel has a blink counter of width clog2(`PARPADEO_DIV`)+1, plus a phase bit.
  - On entry to ACTIVA: phase=1, counter=0.
  - Phase toggles every `PARPADEO_DIV` edges while in ACTIVA.
  - `LUZ[i]` = phase in ACTIVA, so it is 1 for the first `PARPADEO_DIV` cycles.
  - Counter and phase are cleared on leaving ACTIVA.
- Undefined: `LUZ[i]` = 1 steadily in ACTIVA, and no blink logic is generated. `PARPADEO_DIV` is ignored.

## Test plan
- Reset: hold `RST`=0 for 2 edges with all `Button`=1 → `LUZ`=0, `ALARMA`=0, `CUENTA`=0. Release, keep `Button[0]`=1 → `LUZ[0]`=1 after the 3rd sampled-high edge.
- Glitch rejection (`DEBOUNCE_CICLOS`=3): `Button[1]` high for 2 edges, low, high for 2 edges → `LUZ[1]`=0, `CUENTA`=0 throughout.
- ACK with button held:
  - Alarm ch2, then `ACK`=1 for 1 cycle → `LUZ[2]`=0 on the next edge.
  - Keep `Button[2]`=1 for 10 cycles → no re-trigger, `CUENTA` stays 1.
  - Release, then press 3 cycles → `CUENTA`=2.
- Simultaneous events: `Button`=4'b1111 pressed together → all `LUZ`=1 on the same edge, `CUENTA`=4.
  - Repeat with forced count: from `CUENTA`=253, a 4-channel entry → 255.
  - A 5th alarm → stays 255.
- ACK collision: `ACK` held 1 while ch3 completes debounce → ch3 enters ACTIVA and `LUZ[3]`=1. The next edge with `ACK`=1 clears it.
- Blink (macro defined, `PARPADEO_DIV`=8): alarm ch0 → `LUZ[0]` reads 1 for 8 cycles, 0 for 8, 1 for 8. Without the macro → constant 1 for 24 cycles.
